// File: rtl/mem_drv_pkg.sv
// Shared memory-driver definitions: word/byte geometry and unpacker states.
package mem_drv_pkg;

   localparam int BYTE_W = 8;
   localparam int BYTES  = 4;
   localparam int WORD_W = BYTE_W * BYTES;
   localparam int IDX_W  = $clog2(BYTES);

   typedef enum logic {
      UNPK_EMPTY,
      UNPK_SEND
   } unpk_state_e;

endpackage : mem_drv_pkg

// File: rtl/word_unpacker_if.sv
// Word-in / byte-out handshake bundle for the read-path unpacker.
interface word_unpacker_if #(
   parameter int BYTE_W = mem_drv_pkg::BYTE_W,
   parameter int BYTES  = mem_drv_pkg::BYTES
);
   logic [BYTE_W*BYTES-1:0] word_in;
   logic                    word_valid;
   logic                    word_ready;
   logic [BYTE_W-1:0]       byte_out;
   logic                    byte_valid;
   logic                    byte_ready;
   logic                    byte_last;
   logic [7:0]              word_count;

   // Producer of words / consumer of bytes.
   modport mst (
      output word_in, word_valid, byte_ready,
      input  word_ready, byte_out, byte_valid, byte_last, word_count
   );

   // The unpacker itself.
   modport slv (
      input  word_in, word_valid, byte_ready,
      output word_ready, byte_out, byte_valid, byte_last, word_count
   );
endinterface : word_unpacker_if

// File: rtl/byte_select.sv
// Combinational byte picker: returns byte idx_i of word_i, index 0 = MSB byte.
module byte_select #(
   parameter int BYTE_W = 8,
   parameter int BYTES  = 4,
   parameter int IW     = (BYTES > 1) ? $clog2(BYTES) : 1
) (
   input  logic [BYTE_W*BYTES-1:0] word_i,
   input  logic [IW-1:0]           idx_i,
   output logic [BYTE_W-1:0]       byte_o
);
   localparam int WW = BYTE_W * BYTES;

   // Constant-slice mux so every select is a fixed part of the word.
   always_comb begin
      byte_o = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (idx_i == IW'(i)) byte_o = word_i[WW-1-BYTE_W*i -: BYTE_W];
      end
   end
endmodule : byte_select

// File: rtl/word_unpacker.sv
// Read-path unpacker: takes one word, emits its bytes MSB first with
// registered outputs, and streams the next word with no bubble when offered.
module word_unpacker
   import mem_drv_pkg::*;
#(
   parameter int BYTE_W = mem_drv_pkg::BYTE_W,
   parameter int BYTES  = mem_drv_pkg::BYTES
) (
   input  logic         clk,
   input  logic         rst,    // asynchronous, active low
   word_unpacker_if.slv bus
);
   localparam int WW = BYTE_W * BYTES;
   localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(BYTES - 1);
   localparam logic [IW-1:0] IDX_ZERO = '0;

   unpk_state_e       state_q;
   logic [WW-1:0]     hold_q;
   logic [IW-1:0]     idx_q;
   logic [IW-1:0]     idx_nxt;
   logic [BYTE_W-1:0] byte_q;
   logic              vld_q;
   logic              last_q;
   logic [7:0]        cnt_q;
   logic [BYTE_W-1:0] sel_load;
   logic [BYTE_W-1:0] sel_next;
   logic              byte_hs;
   logic              word_hs;

   assign idx_nxt = idx_q + IW'(1);
   assign byte_hs = vld_q && bus.byte_ready;

   // Ready when idle, or when the final byte leaves this cycle; held low in reset.
   assign bus.word_ready = rst && ((state_q == UNPK_EMPTY) || (byte_hs && last_q));
   assign word_hs        = bus.word_valid && bus.word_ready;

   // First byte of an incoming word, and the byte after the current one.
   byte_select #(.BYTE_W(BYTE_W), .BYTES(BYTES)) u_sel_load (
      .word_i (bus.word_in),
      .idx_i  (IDX_ZERO),
      .byte_o (sel_load)
   );

   byte_select #(.BYTE_W(BYTE_W), .BYTES(BYTES)) u_sel_next (
      .word_i (hold_q),
      .idx_i  (idx_nxt),
      .byte_o (sel_next)
   );

   // FSM with registered byte outputs and the completed-word counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= UNPK_EMPTY;
         hold_q  <= '0;
         idx_q   <= '0;
         byte_q  <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            UNPK_EMPTY: begin
               if (word_hs) begin
                  state_q <= UNPK_SEND;
                  hold_q  <= bus.word_in;
                  idx_q   <= '0;
                  byte_q  <= sel_load;
                  vld_q   <= 1'b1;
                  last_q  <= (IDX_LAST == IDX_ZERO);
               end
            end
            UNPK_SEND: begin
               if (byte_hs) begin
                  if (idx_q != IDX_LAST) begin
                     idx_q  <= idx_nxt;
                     byte_q <= sel_next;
                     last_q <= (idx_nxt == IDX_LAST);
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                     if (word_hs) begin
                        // Reload on the same edge as the final byte: no bubble.
                        hold_q <= bus.word_in;
                        idx_q  <= '0;
                        byte_q <= sel_load;
                        last_q <= (IDX_LAST == IDX_ZERO);
                     end else begin
                        state_q <= UNPK_EMPTY;
                        vld_q   <= 1'b0;
                        last_q  <= 1'b0;
                     end
                  end
               end
            end
            default: state_q <= UNPK_EMPTY;
         endcase
      end
   end

   assign bus.byte_out   = byte_q;
   assign bus.byte_valid = vld_q;
   assign bus.byte_last  = last_q;
   assign bus.word_count = cnt_q;
endmodule : word_unpacker

// File: tb/tb_word_unpacker.sv
// Directed bench for word_unpacker: single word, streaming, backpressure,
// mid-word reset and a 256-word wrap run against a byte scoreboard.
module tb_word_unpacker;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   word_unpacker_if #(.BYTE_W(8), .BYTES(4)) bus ();

   word_unpacker #(.BYTE_W(8), .BYTES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Check one emitted byte at the falling edge, then let it be taken.
   task automatic exp_byte(input string tag, input logic [7:0] b, input logic last,
                           input logic wrdy);
      @(negedge clk);
      chk({tag, "_vld"},  bus.byte_valid, 1);
      chk({tag, "_byte"}, bus.byte_out,   b);
      chk({tag, "_last"}, bus.byte_last,  last);
      chk({tag, "_wrdy"}, bus.word_ready, wrdy);
      @(posedge clk); #1;
   endtask

   // Offer a word while idle; returns at the edge it is accepted.
   task automatic offer(input string tag, input logic [31:0] w);
      bus.word_in    = w;
      bus.word_valid = 1'b1;
      bus.byte_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_acc_wrdy"}, bus.word_ready, 1);
      chk({tag, "_acc_vld"},  bus.byte_valid, 0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_vld"},  bus.byte_valid, 0);
      chk({tag, "_byte"}, bus.byte_out,   0);
      chk({tag, "_last"}, bus.byte_last,  0);
      chk({tag, "_wcnt"}, bus.word_count, 0);
      chk({tag, "_wrdy"}, bus.word_ready, 0);
   endtask

   function automatic logic [31:0] mkword(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {b, ~b, b + 8'h5A, b ^ 8'hC3};
   endfunction

   logic [7:0] sbq[$];
   logic [7:0] exp_b;
   logic [31:0] w;
   int wi, done_words, bidx, cyc, bubbles;
   logic prev_last, acc;

   initial begin
      bus.word_in    = '0;
      bus.word_valid = 1'b0;
      bus.byte_ready = 1'b0;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("rst");
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rel_wrdy", bus.word_ready, 1);
      @(posedge clk); #1;

      // ---- single word ----
      offer("w1", 32'hA1B2C3D4);
      bus.word_valid = 1'b0;
      exp_byte("w1_b0", 8'hA1, 0, 0);
      exp_byte("w1_b1", 8'hB2, 0, 0);
      exp_byte("w1_b2", 8'hC3, 0, 0);
      exp_byte("w1_b3", 8'hD4, 1, 1);
      @(negedge clk);
      chk("w1_idle_vld", bus.byte_valid, 0);
      chk("w1_wcnt", bus.word_count, 1);
      @(posedge clk); #1;

      // ---- back-to-back ----
      offer("b2b", 32'h01020304);
      bus.word_in = 32'h05060708;
      for (int k = 0; k < 8; k++) begin
         exp_byte("b2b", 8'(k + 1), (k % 4) == 3, (k % 4) == 3);
         if (k == 3) bus.word_valid = 1'b0;
         if (k == 4) chk("b2b_wcnt_mid", bus.word_count, 2);
      end
      @(negedge clk);
      chk("b2b_idle_vld", bus.byte_valid, 0);
      chk("b2b_wcnt", bus.word_count, 3);
      @(posedge clk); #1;

      // ---- backpressure, with a word offered during the stall ----
      offer("bp", 32'hDEADBEEF);
      bus.word_valid = 1'b0;
      exp_byte("bp_b0", 8'hDE, 0, 0);
      bus.byte_ready = 1'b0;
      bus.word_in    = 32'h12345678;
      bus.word_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_stall_byte", bus.byte_out, 8'hAD);
         chk("bp_stall_vld",  bus.byte_valid, 1);
         chk("bp_stall_last", bus.byte_last, 0);
         chk("bp_stall_wrdy", bus.word_ready, 0);
         @(posedge clk); #1;
      end
      bus.byte_ready = 1'b1;
      bus.word_valid = 1'b0;
      exp_byte("bp_b1", 8'hAD, 0, 0);
      exp_byte("bp_b2", 8'hBE, 0, 0);
      exp_byte("bp_b3", 8'hEF, 1, 1);
      @(negedge clk);
      chk("bp_idle_vld", bus.byte_valid, 0);
      chk("bp_wcnt", bus.word_count, 4);
      @(posedge clk); #1;

      // ---- reset mid-word ----
      offer("mr", 32'h11223344);
      bus.word_valid = 1'b0;
      exp_byte("mr_b0", 8'h11, 0, 0);
      exp_byte("mr_b1", 8'h22, 0, 0);
      chk("mr_pre_byte", bus.byte_out, 8'h33);
      rst = 1'b0;
      #1;
      check_reset("mr_async");
      @(posedge clk); #1;
      check_reset("mr_hold");
      rst = 1'b1;
      offer("mr_next", 32'h55667788);
      bus.word_valid = 1'b0;
      exp_byte("mr_n0", 8'h55, 0, 0);
      exp_byte("mr_n1", 8'h66, 0, 0);
      exp_byte("mr_n2", 8'h77, 0, 0);
      exp_byte("mr_n3", 8'h88, 1, 1);
      @(negedge clk);
      chk("mr_wcnt", bus.word_count, 1);
      @(posedge clk); #1;

      // ---- 256-word wrap against a scoreboard ----
      rst = 1'b0;
      #1;
      rst = 1'b1;
      bus.byte_ready = 1'b1;
      wi = 0; done_words = 0; bidx = 0; cyc = 0; bubbles = 0; prev_last = 1'b0;
      bus.word_in    = mkword(0);
      bus.word_valid = 1'b1;
      while (done_words < 256 && cyc < 3000) begin
         @(negedge clk);
         if (prev_last) chk("wrap_wcnt", bus.word_count, 32'(done_words[7:0]));
         prev_last = 1'b0;
         if (bus.byte_valid && bus.byte_ready) begin
            if (sbq.size() == 0) begin
               chk("wrap_extra_byte", bus.byte_out, 0);
            end else begin
               exp_b = sbq.pop_front();
               chk("wrap_byte", bus.byte_out, exp_b);
            end
            chk("wrap_last", bus.byte_last, (bidx % 4) == 3);
            if (bus.byte_last) begin
               done_words++;
               prev_last = 1'b1;
            end
            bidx++;
         end else if (wi > 0) begin
            bubbles++;
         end
         acc = bus.word_valid && bus.word_ready;
         if (acc) begin
            w = bus.word_in;
            sbq.push_back(w[31:24]);
            sbq.push_back(w[23:16]);
            sbq.push_back(w[15:8]);
            sbq.push_back(w[7:0]);
         end
         @(posedge clk); #1;
         if (acc) begin
            wi++;
            if (wi < 256) bus.word_in = mkword(wi);
            else          bus.word_valid = 1'b0;
         end
         cyc++;
      end
      if (done_words < 256) chk("wrap_timeout", done_words, 256);
      @(negedge clk);
      chk("wrap_wcnt_final", bus.word_count, 0);
      chk("wrap_nbytes", bidx, 1024);
      chk("wrap_sb_left", sbq.size(), 0);
      chk("wrap_bubbles", bubbles, 0);
      chk("wrap_idle_vld", bus.byte_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule : tb_word_unpacker
